ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have one clock and one reset: clk, a single clock with all state on its rising edge; rst, an asynchronous, active-high reset.
REQ-002 SHALL have port clk  input  1  pipeline clock.
REQ-003 SHALL have port rst  input  1  async active-high reset.
REQ-004 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-005 SHALL have port id_ctrl  input  8  decoded control bundle from the ID-stage decoder: [7]RegWrite [6]MemtoReg [5]MemRead [4]MemWrite [3]Branch [2]ALUSrc [1:0]ALUOp.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  ID register indices.
REQ-007 SHALL have port ex_branch_taken  input  1  EX comparison result, meaningful only when ex_ctrl[3]=1.
REQ-008 SHALL have port ex_ctrl  output  8  EX-stage bundle.
REQ-009 SHALL have port mem_ctrl  output  8  MEM-stage bundle.
REQ-010 SHALL have port wb_ctrl  output  8  WB-stage bundle.
REQ-011 SHALL have ports ex_rd, mem_rd, wb_rd  output  5 each  destination index per stage.
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID this cycle.
REQ-013 SHALL have port flush_ifid  output  1  squash IF/ID contents.
REQ-014 SHALL have ports fwd_a, fwd_b  output  2 each  EX operand select: 00 regfile, 10 MEM result, 01 WB result.
REQ-015 SHALL have port stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-016 SHALL advance the pipeline every cycle: EX<=ID (bundle, rs1, rs2, rd), MEM<=EX, WB<=MEM; no stage is ever frozen.
REQ-017 SHALL treat id_valid=0 as a bubble: EX bundle 8'h00, EX rd 0.
REQ-018 SHALL assert stall combinationally when id_valid=1, ex_ctrl[5]=1, ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2).
REQ-019 SHALL, while stall=1, load a bubble (all-zero bundle and indices) into EX at the next edge; the ID instruction is re-presented by the upstream hold.
REQ-020 SHALL assert flush=ex_ctrl[3]&ex_branch_taken combinationally, drive flush_ifid=flush, and load a bubble into EX at the next edge.
REQ-021 SHALL give flush priority over stall on the same cycle (stall forced to 0).
REQ-022 SHALL set fwd_a=10 when mem_ctrl[7]=1, mem_rd!=0 and mem_rd==EX rs1; else 01 when wb_ctrl[7]=1, wb_rd!=0 and wb_rd==EX rs1; else 00 (MEM wins when both match).
REQ-023 SHALL compute fwd_b by the same rule as fwd_a, applied to EX rs2.
REQ-024 SHALL never forward or stall on register x0.
REQ-025 SHALL increment stall_cnt by 1 on each edge where stall=1, holding at 16'hFFFF with no wrap.
REQ-026 SHALL have a decode-to-ex_ctrl latency of exactly 1 cycle and an ex_ctrl-to-wb_ctrl latency of exactly 2 cycles.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear every stage bundle, every rd/rs index and stall_cnt to 0; outputs SHALL then read ex_ctrl=mem_ctrl=wb_ctrl=8'h00, rd=0, fwd_a=fwd_b=00, stall=0, flush_ifid=0.
REQ-028 SHALL, when rst asserts mid-operation, discard all in-flight instructions without writeback; the first edge after release SHALL capture ID normally.

Structure
REQ-029 SHALL place the bundle bit-position constants, the 8'h00 bubble constant and the fwd encodings in shared package cpu_pkg, which the decoder also uses.
REQ-030 SHALL be implemented as one natural sub-module fwd_unit (instantiated twice, for rs1 and rs2); all other logic SHALL be flat.

Verification
REQ-031 SHALL be tested by: LW x5 (id_ctrl 8'hE4), then ADD x6,x5,x1 -> stall=1 for 1 cycle, ex_ctrl=8'h00 next cycle, stall_cnt=1.
REQ-032 SHALL be tested by: ADD x3 (8'h82), then SUB using x3 -> fwd_a=10; with one independent instruction between them -> fwd_a=01.
REQ-033 SHALL be tested by: BEQ (8'h09) in EX with ex_branch_taken=1 while a load-use condition is also present -> flush_ifid=1, stall=0, EX bubble next cycle.
REQ-034 SHALL be tested by: writes and reads to rd=0 (x0) -> fwd_a=fwd_b=00 and stall=0.
REQ-035 SHALL be tested by: rst pulsed mid-stream with three valid instructions in flight -> all bundles read 8'h00 immediately and wb_ctrl[7] never asserts for them.
REQ-036 SHALL be tested by: 65540 forced consecutive stalls -> stall_cnt=16'hFFFF and held there.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared control-bundle layout, bubble value and forwarding encodings.
// Used by the ID decoder and the hazard/forwarding control pipe.
package cpu_pkg;

    localparam int C_REGWRITE = 7;
    localparam int C_MEMTOREG = 6;
    localparam int C_MEMREAD  = 5;
    localparam int C_MEMWRITE = 4;
    localparam int C_BRANCH   = 3;
    localparam int C_ALUSRC   = 2;
    localparam int C_ALUOP_HI = 1;
    localparam int C_ALUOP_LO = 0;

    localparam logic [7:0] CTRL_BUBBLE = 8'h00;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ex_stage_t;

    // x0 is hardwired to zero, so it never produces a dependency
    function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register.
// The youngest producer (MEM) wins over WB.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       mem_wr,
    input  logic [4:0] mem_rd,
    input  logic       wb_wr,
    input  logic [4:0] wb_rd,
    output logic [1:0] fwd
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_wr & rd_hit(mem_rd, rs);
    assign wb_hit  = wb_wr & rd_hit(wb_rd, rs) & ~mem_hit;

    always_comb begin
        fwd = FWD_RF;
        unique case (1'b1)
            mem_hit: fwd = FWD_MEM;
            wb_hit:  fwd = FWD_WB;
            default: fwd = FWD_RF;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID->EX->MEM->WB with load-use stall, branch flush
// and operand forwarding selects.
module ctrl_pipe
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [7:0]  id_ctrl,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        ex_branch_taken,
    output logic [7:0]  ex_ctrl,
    output logic [7:0]  mem_ctrl,
    output logic [7:0]  wb_ctrl,
    output logic [4:0]  ex_rd,
    output logic [4:0]  mem_rd,
    output logic [4:0]  wb_rd,
    output logic        stall,
    output logic        flush_ifid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    ex_stage_t   ex_q;
    logic [7:0]  mem_ctrl_q;
    logic [7:0]  wb_ctrl_q;
    logic [4:0]  mem_rd_q;
    logic [4:0]  wb_rd_q;
    logic [15:0] cnt_q;

    logic flush;
    logic load_use;
    logic bubble;

    assign flush    = ex_q.ctrl[C_BRANCH] & ex_branch_taken;
    assign load_use = id_valid & ex_q.ctrl[C_MEMREAD]
                    & (rd_hit(ex_q.rd, id_rs1) | rd_hit(ex_q.rd, id_rs2));
    // a taken branch kills the dependent instruction anyway
    assign stall    = load_use & ~flush;
    assign bubble   = ~id_valid | stall | flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            mem_ctrl_q <= CTRL_BUBBLE;
            mem_rd_q   <= 5'd0;
            wb_ctrl_q  <= CTRL_BUBBLE;
            wb_rd_q    <= 5'd0;
            cnt_q      <= 16'd0;
        end else begin
            if (bubble) begin
                ex_q <= '0;
            end else begin
                ex_q.ctrl <= id_ctrl;
                ex_q.rs1  <= id_rs1;
                ex_q.rs2  <= id_rs2;
                ex_q.rd   <= id_rd;
            end
            mem_ctrl_q <= ex_q.ctrl;
            mem_rd_q   <= ex_q.rd;
            wb_ctrl_q  <= mem_ctrl_q;
            wb_rd_q    <= mem_rd_q;
            if (stall && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    fwd_unit u_fwd_a (
        .rs     (ex_q.rs1),
        .mem_wr (mem_ctrl_q[C_REGWRITE]),
        .mem_rd (mem_rd_q),
        .wb_wr  (wb_ctrl_q[C_REGWRITE]),
        .wb_rd  (wb_rd_q),
        .fwd    (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs     (ex_q.rs2),
        .mem_wr (mem_ctrl_q[C_REGWRITE]),
        .mem_rd (mem_rd_q),
        .wb_wr  (wb_ctrl_q[C_REGWRITE]),
        .wb_rd  (wb_rd_q),
        .fwd    (fwd_b)
    );

    assign ex_ctrl    = ex_q.ctrl;
    assign ex_rd      = ex_q.rd;
    assign mem_ctrl   = mem_ctrl_q;
    assign mem_rd     = mem_rd_q;
    assign wb_ctrl    = wb_ctrl_q;
    assign wb_rd      = wb_rd_q;
    assign flush_ifid = flush;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: hazards, forwarding, flush, reset
// and stall counter saturation.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_ctrl;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        ex_branch_taken;
    logic [7:0]  ex_ctrl;
    logic [7:0]  mem_ctrl;
    logic [7:0]  wb_ctrl;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        flush_ifid;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  exq[$];
    logic [4:0]  rdq[$];
    logic [7:0]  wbq[$];
    logic [7:0]  m_ex_ctrl;
    logic [4:0]  m_ex_rd;
    logic [15:0] m_cnt;

    ctrl_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_ctrl         (id_ctrl),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_ctrl         (ex_ctrl),
        .mem_ctrl        (mem_ctrl),
        .wb_ctrl         (wb_ctrl),
        .ex_rd           (ex_rd),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .stall           (stall),
        .flush_ifid      (flush_ifid),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0;
        id_ctrl = 8'h00;
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        id_rd = 5'd0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic model_clear();
        exq.delete();
        rdq.delete();
        wbq.delete();
        wbq.push_back(8'h00);
        wbq.push_back(8'h00);
        m_ex_ctrl = 8'h00;
        m_ex_rd = 5'd0;
        m_cnt = 16'd0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ex"}, ex_ctrl, 8'h00);
        chk({tag, "_mem"}, mem_ctrl, 8'h00);
        chk({tag, "_wb"}, wb_ctrl, 8'h00);
        chk({tag, "_rd"}, {ex_rd, mem_rd, wb_rd}, 15'd0);
        chk({tag, "_fwd"}, {fwd_a, fwd_b}, 4'b0000);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_flush"}, flush_ifid, 1'b0);
        chk({tag, "_cnt"}, stall_cnt, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic v, input logic [7:0] c,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic tk);
        logic fl;
        logic st;
        logic [7:0] e;
        logic [4:0] erd;
        @(negedge clk);
        id_valid = v;
        id_ctrl = c;
        id_rs1 = r1;
        id_rs2 = r2;
        id_rd = rd;
        ex_branch_taken = tk;
        #1;
        fl = m_ex_ctrl[3] & tk;
        st = v & m_ex_ctrl[5] & (m_ex_rd != 5'd0)
           & (m_ex_rd == r1 || m_ex_rd == r2) & ~fl;
        chk("flush_ifid", flush_ifid, fl);
        chk("stall", stall, st);
        e = (v && !st && !fl) ? c : 8'h00;
        erd = (v && !st && !fl) ? rd : 5'd0;
        exq.push_back(e);
        rdq.push_back(erd);
        if (st && m_cnt != 16'hFFFF) m_cnt++;
        @(posedge clk);
        #1;
        chk("ex_ctrl", ex_ctrl, exq.pop_front());
        chk("ex_rd", ex_rd, rdq.pop_front());
        chk("wb_ctrl", wb_ctrl, wbq.pop_front());
        wbq.push_back(e);
        chk("stall_cnt", stall_cnt, m_cnt);
        m_ex_ctrl = e;
        m_ex_rd = erd;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        rst = 1'b1;
        #1;
        chk_reset_state("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // load-use: LW x5 then ADD x6,x5,x1
        step(1'b1, 8'hE4, 5'd2, 5'd0, 5'd5, 1'b0);
        step(1'b1, 8'h82, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("lu_bubble", ex_ctrl, 8'h00);
        chk("lu_cnt", stall_cnt, 16'd1);
        step(1'b1, 8'h82, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);

        // EX->EX forwarding from MEM, then from WB, then MEM priority
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b1, 8'h82, 5'd3, 5'd4, 5'd7, 1'b0);
        chk("fwd_mem_a", fwd_a, 2'b10);
        chk("fwd_mem_b", fwd_b, 2'b00);
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b1, 8'h82, 5'd8, 5'd9, 5'd10, 1'b0);
        step(1'b1, 8'h82, 5'd3, 5'd4, 5'd11, 1'b0);
        chk("fwd_wb_a", fwd_a, 2'b01);
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b1, 8'h82, 5'd3, 5'd3, 5'd12, 1'b0);
        chk("fwd_pri_a", fwd_a, 2'b10);
        chk("fwd_pri_b", fwd_b, 2'b10);
        step(1'b1, 8'h82, 5'd13, 5'd3, 5'd14, 1'b0);
        chk("fwd_wb_b", fwd_b, 2'b01);

        // taken branch, alone and together with a load-use hazard
        step(1'b1, 8'h09, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd4, 1'b1);
        chk("br_bubble", ex_ctrl, 8'h00);
        step(1'b1, 8'h29, 5'd1, 5'd2, 5'd5, 1'b0);
        step(1'b1, 8'h82, 5'd5, 5'd0, 5'd6, 1'b1);
        chk("br_lu_cnt", stall_cnt, m_cnt);
        step(1'b1, 8'h29, 5'd1, 5'd2, 5'd5, 1'b0);
        step(1'b1, 8'h82, 5'd5, 5'd0, 5'd6, 1'b0);
        chk("nt_lu_bubble", ex_ctrl, 8'h00);

        // x0 never forwards or stalls
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 8'h82, 5'd0, 5'd0, 5'd5, 1'b0);
        chk("x0_fwd", {fwd_a, fwd_b}, 4'b0000);
        step(1'b1, 8'hE4, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 8'h82, 5'd0, 5'd0, 5'd6, 1'b0);
        chk("x0_ld_ex", ex_ctrl, 8'h82);
        step(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("x0_wb_fwd", {fwd_a, fwd_b}, 4'b0000);

        // mid-stream reset discards three in-flight writers
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd20, 1'b0);
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd21, 1'b0);
        step(1'b1, 8'h82, 5'd1, 5'd2, 5'd22, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_reset_state("mid");
        @(negedge clk);
        id_valid = 1'b1;
        id_ctrl = 8'hC6;
        id_rs1 = 5'd1;
        id_rs2 = 5'd2;
        id_rd = 5'd9;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ex", ex_ctrl, 8'hC6);
        chk("post_rst_rd", ex_rd, 5'd9);
        model_clear();
        wbq.delete();
        wbq.push_back(8'h00);
        wbq.push_back(8'hC6);
        m_ex_ctrl = 8'hC6;
        m_ex_rd = 5'd9;
        step(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("rst_wb_we0", wb_ctrl[7], 1'b0);
        step(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("rst_wb_we1", wb_ctrl[7], 1'b0);

        // saturation: LW x5,0(x5) held in ID stalls every other cycle
        do_reset();
        @(negedge clk);
        id_valid = 1'b1;
        id_ctrl = 8'hE4;
        id_rs1 = 5'd5;
        id_rs2 = 5'd0;
        id_rd = 5'd5;
        repeat (2000) @(posedge clk);
        #1;
        chk("sat_mid", stall_cnt, 16'd1000);
        repeat (2 * 65540 - 2000) @(posedge clk);
        #1;
        chk("sat_full", stall_cnt, 16'hFFFF);
        repeat (10) @(posedge clk);
        #1;
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
